// File: rtl/serial_addsub_sched_if.sv
// rtl/serial_addsub_sched_if.sv - requester, FA-cell and response signals of the serial add/sub sequencer
//
// Purpose: bundles the two request channels, the external full-adder cell
// handshake and the response channel into one interface.
// Ports (signals):
//   req0_*/req1_* : valid/ready handshake, sub select, WIDTH-bit operands a/b
//   fa_*          : fa_valid/fa_a/fa_b/fa_ci to the FA cell, fa_ack/fa_s/fa_co back
//   rsp_*         : rsp_valid/rsp_ready handshake, rsp_id, WIDTH+1-bit rsp_y
// Modports: slave = sequencer side, master = environment side.

interface serial_addsub_sched_if #(
    parameter int WIDTH = 8,
    parameter int IDW   = 1
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_sub;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_sub;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             fa_valid;
    logic             fa_a;
    logic             fa_b;
    logic             fa_ci;
    logic             fa_ack;
    logic             fa_s;
    logic             fa_co;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH:0]   rsp_y;

    modport slave (
        input  req0_valid, req0_sub, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_sub, req1_a, req1_b,
        output req1_ready,
        output fa_valid, fa_a, fa_b, fa_ci,
        input  fa_ack, fa_s, fa_co,
        output rsp_valid, rsp_id, rsp_y,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_sub, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_sub, req1_a, req1_b,
        input  req1_ready,
        input  fa_valid, fa_a, fa_b, fa_ci,
        output fa_ack, fa_s, fa_co,
        input  rsp_valid, rsp_id, rsp_y,
        output rsp_ready
    );
endinterface

// File: rtl/serial_addsub_sched.sv
// rtl/serial_addsub_sched.sv - round-robin sequencer driving one shared full-adder cell bit-serially
//
// Purpose: accepts an add/sub request from one of two requesters, evaluates
// it one bit per FA handshake (LSB first) and returns {carry_out, sum}.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : serial_addsub_sched_if.slave (request, FA-cell and response channels)

module serial_addsub_sched #(
    parameter int WIDTH = 8,
    parameter int IDW   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_addsub_sched_if.slave   bus
);
    localparam int             IXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IXW-1:0] LAST = IXW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_n;

    logic             rr;        // 1 = requester 1 wins a tie
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic [IDW-1:0]   id_r;
    logic [IXW-1:0]   idx;
    logic             carry;
    logic [WIDTH:0]   y_r;
    logic             grant1;

    assign grant1      = bus.req1_valid && (!bus.req0_valid || rr);
    assign bus.rsp_y   = y_r;
    assign bus.rsp_id  = id_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FA outputs are gated by state so they read zero outside EXEC; during
    // EXEC they only change on an ack, which keeps them stable while waiting.
    always_comb begin
        state_n        = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.fa_valid   = 1'b0;
        bus.fa_a       = 1'b0;
        bus.fa_b       = 1'b0;
        bus.fa_ci      = 1'b0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid && !grant1;
                bus.req1_ready = grant1;
                if (bus.req0_valid || bus.req1_valid) begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                bus.fa_valid = 1'b1;
                bus.fa_a     = a_r[idx];
                bus.fa_b     = b_r[idx] ^ sub_r;
                bus.fa_ci    = carry;
                if (bus.fa_ack && (idx == LAST)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr    <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            id_r  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            y_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_ready || bus.req1_ready) begin
                        a_r   <= grant1 ? bus.req1_a   : bus.req0_a;
                        b_r   <= grant1 ? bus.req1_b   : bus.req0_b;
                        sub_r <= grant1 ? bus.req1_sub : bus.req0_sub;
                        // Subtraction is a + ~b + 1: the +1 enters as carry-in of bit 0.
                        carry <= grant1 ? bus.req1_sub : bus.req0_sub;
                        id_r  <= IDW'(grant1);
                        idx   <= '0;
                        y_r   <= '0;
                        rr    <= !grant1;
                    end
                end
                EXEC: begin
                    if (bus.fa_ack) begin
                        y_r[idx] <= bus.fa_s;
                        carry    <= bus.fa_co;
                        if (idx == LAST) begin
                            y_r[WIDTH] <= bus.fa_co;
                        end else begin
                            idx <= idx + IXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_sched.sv
// tb/tb_serial_addsub_sched.sv - self-checking bench for serial_addsub_sched

module tb_serial_addsub_sched;
    localparam int W  = 8;
    localparam int W1 = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_addsub_sched_if #(.WIDTH(W)) bus ();
    serial_addsub_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-adder cell: answers fa_delay cycles after each new operand set.
    int fa_delay = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        if (rst || !bus.fa_valid || bus.fa_ack) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end
    assign bus.fa_ack = bus.fa_valid && (wait_cnt >= fa_delay);
    assign bus.fa_s   = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
    assign bus.fa_co  = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_ci) | (bus.fa_b & bus.fa_ci);

    // Observers: FA busy cycles and operand stability while waiting for ack.
    int       exec_cnt  = 0;
    int       stab_bad  = 0;
    int       stab_seen = 0;
    bit       stab_en   = 0;
    bit       prev_wait = 0;
    logic [2:0] prev_fa = '0;
    always @(negedge clk) begin
        if (bus.fa_valid) exec_cnt <= exec_cnt + 1;
        if (stab_en && prev_wait && bus.fa_valid) begin
            stab_seen <= stab_seen + 1;
            if ({bus.fa_a, bus.fa_b, bus.fa_ci} != prev_fa) stab_bad <= stab_bad + 1;
        end
        prev_wait <= bus.fa_valid && !bus.fa_ack;
        prev_fa   <= {bus.fa_a, bus.fa_b, bus.fa_ci};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        logic [W-1:0] d;
        if (s) begin
            d = W'(ai - bi);
            return {(ai >= bi), d};
        end
        return W1'(ai + bi);
    endfunction

    task automatic drive(input int who, input logic v, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin
            bus.req0_sub = s; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = v;
        end else begin
            bus.req1_sub = s; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = v;
        end
    endtask

    // Starts at a negedge; returns at the negedge of the first EXEC cycle.
    task automatic start_op(input int who, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        bit ok = 0;
        acc = 0;
        @(negedge clk);
        drive(who, 1'b1, s, a, b);
        for (int k = 0; k < 200; k++) begin
            #1;
            if (who == 0 ? bus.req0_ready : bus.req1_ready) begin
                ok  = 1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 1);
        @(posedge clk);
        @(negedge clk);
        drive(who, 1'b0, s, a, b);
        if (ok) begin
            check("bit0_fa_valid", 32'(bus.fa_valid), 1);
            check("bit0_fa_ci", 32'(bus.fa_ci), 32'(s));
        end
    endtask

    task automatic finish_op(input int who, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int acc, input int exp_lat);
        bit ok = 0;
        for (int k = 0; k < 600; k++) begin
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", 32'(ok), 1);
        if (ok) begin
            check("latency", 32'(cyc - acc), 32'(exp_lat));
            check("rsp_y", 32'(bus.rsp_y), 32'(model(s, a, b)));
            check("rsp_id", 32'(bus.rsp_id), 32'(who));
        end
    endtask

    task automatic run_op(input int who, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
        int acc;
        start_op(who, s, a, b, acc);
        finish_op(who, s, a, b, acc, exp_lat);
    endtask

    // At a negedge: waits until any ready is high, returns at negedge+1 of that cycle.
    task automatic wait_any_ready(output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("ready_seen", 32'(ok), 1);
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_wait", 32'(ok), 1);
    endtask

    initial begin
        int  acc, e0, c_prev, c_now, n_rsp;
        bit  ok;
        logic [W:0] exp_y;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_fa_valid", 32'(bus.fa_valid), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_fa_abc", 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 0);
        check("rst_rsp_y", 32'(bus.rsp_y), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
        rst = 1'b0;

        // Add and subtract, fa_ack tied high
        run_op(0, 1'b0, 8'd200, 8'd100, W + 1);
        check("add_200_100", 32'(bus.rsp_y), 32'h12C);
        run_op(1, 1'b1, 8'd5, 8'd3, W + 1);
        check("sub_5_3", 32'(bus.rsp_y), 32'h102);
        run_op(1, 1'b1, 8'd3, 8'd5, W + 1);
        check("sub_3_5", 32'(bus.rsp_y), 32'h0FE);

        // Arbitration from reset: both hold 1+1, grants alternate 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 8'd1, 8'd1);
        drive(1, 1'b1, 1'b0, 8'd1, 8'd1);
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(ok);
            if (ok) begin
                check("arb_grant", 32'({bus.req1_ready, bus.req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
                @(posedge clk);
                @(negedge clk);
                wait_rsp(ok);
                if (ok) begin
                    check("arb_rsp_id", 32'(bus.rsp_id), 32'(k % 2));
                    check("arb_rsp_y", 32'(bus.rsp_y), 32'h002);
                end
            end
            @(negedge clk);
        end

        // Single requester back-to-back: one accept every W+2 cycles
        drive(1, 1'b0, 1'b0, 8'd1, 8'd1);
        c_prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(ok);
            c_now = cyc;
            if (ok && c_prev >= 0) check("b2b_period", 32'(c_now - c_prev), 32'(W + 2));
            c_prev = c_now;
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 8'd1, 8'd1);
        repeat (2 * W) @(negedge clk);

        // Slow FA: ack 3 cycles after each operand change
        fa_delay = 3;
        stab_en  = 1;
        #1 e0 = exec_cnt;
        start_op(0, 1'b0, 8'd255, 8'd1, acc);
        finish_op(0, 1'b0, 8'd255, 8'd1, acc, 4 * W + 1);
        check("slow_y", 32'(bus.rsp_y), 32'h100);
        #1;
        check("slow_exec_len", 32'(exec_cnt - e0), 32'(4 * W));
        check("slow_hold_seen", 32'(stab_seen), 32'(3 * W));
        check("slow_hold_bad", 32'(stab_bad), 0);
        stab_en  = 0;
        fa_delay = 0;

        // Response backpressure
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        start_op(0, 1'b1, 8'd77, 8'd150, acc);
        drive(1, 1'b1, 1'b0, 8'd9, 8'd9);
        exp_y = model(1'b1, 8'd77, 8'd150);
        wait_rsp(ok);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check("bp_rsp_y", 32'(bus.rsp_y), 32'(exp_y));
            check("bp_rsp_id", 32'(bus.rsp_id), 0);
            check("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_release_rsp", 32'(bus.rsp_valid), 0);
        check("bp_release_idle", 32'(bus.req1_ready), 1);
        drive(1, 1'b0, 1'b0, 8'd9, 8'd9);
        @(negedge clk);
        check("dropped_req_ready", 32'(bus.req1_ready), 0);
        repeat (3) @(negedge clk);
        check("dropped_req_noexec", 32'(bus.fa_valid), 0);

        // Reset during bit 4 of an add
        start_op(0, 1'b0, 8'hA5, 8'h3C, acc);
        repeat (4) @(negedge clk);
        check("mid_bit4_a", 32'(bus.fa_a), 32'(1'b0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_fa_valid", 32'(bus.fa_valid), 0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        check("abort_fa_abc", 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 0);
        check("abort_rsp", 32'({bus.rsp_id, bus.rsp_y}), 0);
        rst = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        check("abort_no_rsp", 32'(n_rsp), 0);
        run_op(0, 1'b0, 8'd7, 8'd9, W + 1);
        check("after_abort_y", 32'(bus.rsp_y), 32'h010);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            int          who;
            logic        s;
            logic [W-1:0] a, b;
            who      = int'($urandom_range(0, 1));
            s        = 1'($urandom_range(0, 1));
            a        = W'($urandom);
            b        = W'($urandom);
            fa_delay = int'($urandom_range(0, 2));
            run_op(who, s, a, b, W * (fa_delay + 1) + 1);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
